trace_repo_port_arbiter: RTL and testbench

TRACE_REPO_PORT_ARBITER -- requirements
Module: trace_repo_port_arbiter

---
 rtl/trace_repository_datatypes.sv | 26 ++
 rtl/trace_repo_port_arbiter_if.sv | 46 ++++
 rtl/rr_arbiter.sv | 34 +++
 rtl/trace_repo_port_arbiter_chan.sv | 125 ++++++++++++
 rtl/trace_repo_port_arbiter.sv | 91 +++++++++
 tb/tb_trace_repo_port_arbiter.sv | 488 ++++++++++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/trace_repository_datatypes.sv
// Shared trace-repository types: entry count, mark-done payload
// and the channel state encoding used by the port arbiter.
package trace_repository_datatypes;

  localparam int TRACE_ENTRIES = 64;
  localparam int IDX_W = $clog2(TRACE_ENTRIES);
  localparam int PL_AW = 16;

  typedef struct packed {
    logic [IDX_W-1:0] index;
    logic             processing;
    logic             mem_trace;
    logic [PL_AW-1:0] addr;
  } done_payload_t;

  typedef enum logic [1:0] {
    CH_IDLE    = 2'd0,
    CH_ISSUE   = 2'd1,
    CH_RELEASE = 2'd2
  } ch_state_e;

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/trace_repo_port_arbiter_if.sv
// Repository-side port bundle: mark-done channel and index lookup.
// master = arbiter, slave = repository.
interface trace_repo_port_arbiter_if #(
  parameter int AW = 16
);
  import trace_repository_datatypes::*;

  logic             mark_done_o;
  logic [IDX_W-1:0] index_done_o;
  logic             processing_flag_o;
  logic             mem_trace_flag_o;
  logic [AW-1:0]    mem_addr_o;
  logic             mark_done_valid_i;

  logic             get_index_o;
  logic [AW-1:0]    addr_o;
  logic [IDX_W-1:0] index_i;
  logic             index_valid_i;

  modport master (
    output mark_done_o,
    output index_done_o,
    output processing_flag_o,
    output mem_trace_flag_o,
    output mem_addr_o,
    input  mark_done_valid_i,
    output get_index_o,
    output addr_o,
    input  index_i,
    input  index_valid_i
  );

  modport slave (
    input  mark_done_o,
    input  index_done_o,
    input  processing_flag_o,
    input  mem_trace_flag_o,
    input  mem_addr_o,
    output mark_done_valid_i,
    input  get_index_o,
    input  addr_o,
    output index_i,
    output index_valid_i
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin pick: first pending requester at or after base_i,
// wrapping at NUM_REQ. One-hot grant plus binary index.
module rr_arbiter
  import trace_repository_datatypes::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IW = ptr_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      base_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IW-1:0]      idx_o
);

  logic found;
  int   j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(base_i) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/trace_repo_port_arbiter_chan.sv
// One repository channel: IDLE -> ISSUE -> RELEASE with round-robin
// grant, payload capture, lock abort and sticky timeout.
module trace_repo_port_arbiter_chan
  import trace_repository_datatypes::*;
#(
  parameter int NUM_REQ = 2,
  parameter int PW = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       lock_i,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [NUM_REQ-1:0][PW-1:0] pl_i,
  input  logic                       valid_i,
  output logic                       strobe_o,
  output logic [PW-1:0]              pl_o,
  output logic [NUM_REQ-1:0]         ack_o,
  output logic                       accept_o,
  output logic                       tmo_o
);

  localparam int IW = ptr_w(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] LAST = IW'(NUM_REQ - 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES - 1);

  ch_state_e          state_q, state_d;
  logic [IW-1:0]      last_q, last_d;
  logic [IW-1:0]      gidx_q, gidx_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               strobe_q, strobe_d;
  logic               tmo_q, tmo_d;
  logic [PW-1:0]      pl_q, pl_d;

  logic [IW-1:0]      base;
  logic [IW-1:0]      arb_idx;
  logic [NUM_REQ-1:0] arb_gnt;

  assign base = (last_q == LAST) ? '0 : last_q + 1'b1;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr (
    .req_i (req_i),
    .base_i(base),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx)
  );

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    gidx_d   = gidx_q;
    gnt_d    = gnt_q;
    cnt_d    = cnt_q;
    strobe_d = strobe_q;
    tmo_d    = tmo_q;
    pl_d     = pl_q;
    ack_d    = '0;
    accept_o = 1'b0;
    unique case (state_q)
      CH_IDLE: begin
        if (lock_i && |req_i) begin
          gnt_d    = arb_gnt;
          gidx_d   = arb_idx;
          pl_d     = pl_i[arb_idx];
          strobe_d = 1'b1;
          cnt_d    = '0;
          state_d  = CH_ISSUE;
        end
      end
      CH_ISSUE: begin
        // lock loss abandons the grant; last_q stays so it re-wins
        if (!lock_i) begin
          strobe_d = 1'b0;
          state_d  = CH_IDLE;
        end else if (valid_i || cnt_q == TMAX) begin
          strobe_d = 1'b0;
          ack_d    = gnt_q;
          last_d   = gidx_q;
          accept_o = valid_i;
          tmo_d    = tmo_q | ~valid_i;
          state_d  = CH_RELEASE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CH_RELEASE: state_d = CH_IDLE;
      default:    state_d = CH_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= CH_IDLE;
      last_q   <= LAST;
      gidx_q   <= '0;
      gnt_q    <= '0;
      ack_q    <= '0;
      cnt_q    <= '0;
      strobe_q <= 1'b0;
      tmo_q    <= 1'b0;
      pl_q     <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      gidx_q   <= gidx_d;
      gnt_q    <= gnt_d;
      ack_q    <= ack_d;
      cnt_q    <= cnt_d;
      strobe_q <= strobe_d;
      tmo_q    <= tmo_d;
      pl_q     <= pl_d;
    end
  end

  assign strobe_o = strobe_q;
  assign pl_o     = pl_q;
  assign ack_o    = ack_q;
  assign tmo_o    = tmo_q;

endmodule

// File: rtl/trace_repo_port_arbiter.sv
// Shares the repository mark-done and index-lookup ports among
// NUM_REQ requesters with two independent channel FSMs.
module trace_repo_port_arbiter
  import trace_repository_datatypes::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_ADDR_WIDTH = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    lock,
  input  logic [NUM_REQ-1:0]                      done_req_i,
  input  done_payload_t [NUM_REQ-1:0]             done_payload_i,
  output logic [NUM_REQ-1:0]                      done_ack_o,
  input  logic [NUM_REQ-1:0]                      idx_req_i,
  input  logic [NUM_REQ-1:0][DATA_ADDR_WIDTH-1:0] idx_addr_i,
  output logic [NUM_REQ-1:0]                      idx_ack_o,
  output logic [IDX_W-1:0]                        idx_index_o,
  trace_repo_port_arbiter_if.master               repo,
  output logic [1:0]                              timeout_err_o
);

  localparam int PLW = $bits(done_payload_t);

  logic                       done_strobe;
  logic [PLW-1:0]             done_pl_w;
  done_payload_t              done_pl;
  logic                       unused_done_acc;
  logic                       idx_strobe;
  logic [DATA_ADDR_WIDTH-1:0] idx_addr_q;
  logic                       idx_acc;
  logic [IDX_W-1:0]           idx_index_q;

  trace_repo_port_arbiter_chan #(
    .NUM_REQ       (NUM_REQ),
    .PW            (PLW),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_done (
    .clk     (clk),
    .rst_n   (rst_n),
    .lock_i  (lock),
    .req_i   (done_req_i),
    .pl_i    (done_payload_i),
    .valid_i (repo.mark_done_valid_i),
    .strobe_o(done_strobe),
    .pl_o    (done_pl_w),
    .ack_o   (done_ack_o),
    .accept_o(unused_done_acc),
    .tmo_o   (timeout_err_o[0])
  );

  trace_repo_port_arbiter_chan #(
    .NUM_REQ       (NUM_REQ),
    .PW            (DATA_ADDR_WIDTH),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idx (
    .clk     (clk),
    .rst_n   (rst_n),
    .lock_i  (lock),
    .req_i   (idx_req_i),
    .pl_i    (idx_addr_i),
    .valid_i (repo.index_valid_i),
    .strobe_o(idx_strobe),
    .pl_o    (idx_addr_q),
    .ack_o   (idx_ack_o),
    .accept_o(idx_acc),
    .tmo_o   (timeout_err_o[1])
  );

  // lookup result lands in the same cycle as idx_ack_o
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_index_q <= '0;
    end else if (idx_acc) begin
      idx_index_q <= repo.index_i;
    end
  end

  assign done_pl     = done_payload_t'(done_pl_w);
  assign idx_index_o = idx_index_q;

  assign repo.mark_done_o       = done_strobe;
  assign repo.index_done_o      = done_pl.index;
  assign repo.processing_flag_o = done_pl.processing;
  assign repo.mem_trace_flag_o  = done_pl.mem_trace;
  assign repo.mem_addr_o        = DATA_ADDR_WIDTH'(done_pl.addr);
  assign repo.get_index_o       = idx_strobe;
  assign repo.addr_o            = idx_addr_q;

endmodule

// File: tb/tb_trace_repo_port_arbiter.sv
// Bench for trace_repo_port_arbiter: directed scenarios plus a
// randomized run against a transaction-level channel model.
module tb_trace_repo_port_arbiter;
  import trace_repository_datatypes::*;

  logic                  clk;
  logic                  rst_n;
  logic                  lock;
  logic [1:0]            done_req;
  done_payload_t [1:0]   done_pl;
  logic [1:0]            done_ack;
  logic [1:0]            idx_req;
  logic [1:0][15:0]      idx_addr;
  logic [1:0]            idx_ack;
  logic [IDX_W-1:0]      idx_index;
  logic [1:0]            tmo_err;

  int n_run;
  int n_fail;

  trace_repo_port_arbiter_if #(.AW(16)) repo ();

  trace_repo_port_arbiter #(
    .NUM_REQ        (2),
    .DATA_ADDR_WIDTH(16),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .lock          (lock),
    .done_req_i    (done_req),
    .done_payload_i(done_pl),
    .done_ack_o    (done_ack),
    .idx_req_i     (idx_req),
    .idx_addr_i    (idx_addr),
    .idx_ack_o     (idx_ack),
    .idx_index_o   (idx_index),
    .repo          (repo),
    .timeout_err_o (tmo_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    lock     = 1'b0;
    done_req = '0;
    idx_req  = '0;
    done_pl  = '0;
    idx_addr = '0;
    repo.mark_done_valid_i = 1'b0;
    repo.index_valid_i     = 1'b0;
    repo.index_i           = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic int rr_pick(int last, logic [1:0] req);
    for (int k = 1; k <= 2; k++) begin
      if (req[(last + k) % 2]) return (last + k) % 2;
    end
    return -1;
  endfunction

  task automatic test_reset();
    logic [63:0] all;
    rst_n = 1'b0;
    clear_inputs();
    #1;
    all = {repo.mark_done_o, repo.get_index_o, done_ack, idx_ack,
           idx_index, tmo_err, repo.mem_addr_o, repo.addr_o,
           repo.index_done_o, repo.processing_flag_o,
           repo.mem_trace_flag_o};
    n_run++;
    if (all !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%0h exp=0", all);
    end
    do_reset();
    n_run++;
    if (repo.mark_done_o !== 1'b0 || done_ack !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_release got=%b%b exp=000",
               repo.mark_done_o, done_ack);
    end
  endtask

  task automatic test_single();
    do_reset();
    lock = 1'b1;
    done_pl[0] = '{index: 6'd5, processing: 1'b1,
                   mem_trace: 1'b0, addr: 16'h0040};
    done_pl[1] = '{index: 6'd9, processing: 1'b0,
                   mem_trace: 1'b1, addr: 16'h0bad};
    done_req = 2'b01;
    tick();
    n_run++;
    if (repo.mark_done_o !== 1'b1 || repo.index_done_o !== 6'd5 ||
        repo.mem_addr_o !== 16'h0040 ||
        repo.processing_flag_o !== 1'b1 ||
        repo.mem_trace_flag_o !== 1'b0 || done_ack !== 2'b00) begin
      n_fail++;
      $display("FAIL single_issue got=%b %0d %h %b%b ack=%b exp=1 5 0040 10 ack=00",
               repo.mark_done_o, repo.index_done_o, repo.mem_addr_o,
               repo.processing_flag_o, repo.mem_trace_flag_o, done_ack);
    end
    tick();
    n_run++;
    if (repo.mark_done_o !== 1'b1 || done_ack !== 2'b00) begin
      n_fail++;
      $display("FAIL single_hold got=%b ack=%b exp=1 ack=00",
               repo.mark_done_o, done_ack);
    end
    repo.mark_done_valid_i = 1'b1;
    tick();
    n_run++;
    if (done_ack !== 2'b01 || repo.mark_done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL single_ack got=ack %b stb %b exp=ack 01 stb 0",
               done_ack, repo.mark_done_o);
    end
    repo.mark_done_valid_i = 1'b0;
    done_req = 2'b00;
    tick();
    n_run++;
    if (done_ack !== 2'b00 || repo.mark_done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL single_release got=ack %b stb %b exp=ack 00 stb 0",
               done_ack, repo.mark_done_o);
    end
  endtask

  task automatic test_lookup();
    do_reset();
    lock = 1'b1;
    idx_addr[1] = 16'h1234;
    idx_addr[0] = 16'h5555;
    idx_req = 2'b10;
    tick();
    n_run++;
    if (repo.get_index_o !== 1'b1 || repo.addr_o !== 16'h1234) begin
      n_fail++;
      $display("FAIL lookup_issue got=%b %h exp=1 1234",
               repo.get_index_o, repo.addr_o);
    end
    repo.index_i       = 6'd7;
    repo.index_valid_i = 1'b1;
    tick();
    n_run++;
    if (idx_ack !== 2'b10 || idx_index !== 6'd7 ||
        repo.get_index_o !== 1'b0) begin
      n_fail++;
      $display("FAIL lookup_ack got=ack %b idx %0d stb %b exp=10 7 0",
               idx_ack, idx_index, repo.get_index_o);
    end
    repo.index_valid_i = 1'b0;
    repo.index_i       = 6'd0;
    idx_req = 2'b00;
    tick();
    n_run++;
    if (idx_ack !== 2'b00) begin
      n_fail++;
      $display("FAIL lookup_pulse got=%b exp=00", idx_ack);
    end
  endtask

  task automatic test_contention();
    int n;
    logic [1:0] exp_ack;
    do_reset();
    lock = 1'b1;
    done_pl[0] = '{index: 6'd1, processing: 1'b0,
                   mem_trace: 1'b0, addr: 16'h0100};
    done_pl[1] = '{index: 6'd2, processing: 1'b0,
                   mem_trace: 1'b0, addr: 16'h0200};
    done_req = 2'b11;
    for (int t = 0; t < 4; t++) begin
      n = 0;
      while (repo.mark_done_o !== 1'b1 && n < 10) begin
        tick();
        n++;
      end
      exp_ack = (t % 2 == 0) ? 2'b01 : 2'b10;
      n_run++;
      if (repo.mark_done_o !== 1'b1 ||
          repo.index_done_o !== 6'(t % 2 + 1)) begin
        n_fail++;
        $display("FAIL contention_grant%0d got=stb %b idx %0d exp=1 %0d",
                 t, repo.mark_done_o, repo.index_done_o, t % 2 + 1);
      end
      repo.mark_done_valid_i = 1'b1;
      tick();
      repo.mark_done_valid_i = 1'b0;
      n_run++;
      if (done_ack !== exp_ack) begin
        n_fail++;
        $display("FAIL contention_ack%0d got=%b exp=%b",
                 t, done_ack, exp_ack);
      end
    end
    done_req = 2'b00;
    tick();
  endtask

  task automatic test_timeout();
    int cnt;
    do_reset();
    lock = 1'b1;
    done_req = 2'b01;
    tick();
    cnt = 0;
    while (repo.mark_done_o === 1'b1 && cnt < 20) begin
      cnt++;
      tick();
    end
    n_run++;
    if (cnt != 4 || done_ack !== 2'b01 || tmo_err !== 2'b01) begin
      n_fail++;
      $display("FAIL timeout_fire got=cyc %0d ack %b err %b exp=4 01 01",
               cnt, done_ack, tmo_err);
    end
    done_req = 2'b00;
    tick();
    tick();
    n_run++;
    if (tmo_err !== 2'b01 || done_ack !== 2'b00) begin
      n_fail++;
      $display("FAIL timeout_sticky got=err %b ack %b exp=01 00",
               tmo_err, done_ack);
    end
  endtask

  task automatic test_abort();
    do_reset();
    lock = 1'b1;
    done_pl[0] = '{index: 6'd1, processing: 1'b0,
                   mem_trace: 1'b0, addr: 16'h0010};
    done_pl[1] = '{index: 6'd2, processing: 1'b0,
                   mem_trace: 1'b0, addr: 16'h0020};
    done_req = 2'b11;
    tick();
    n_run++;
    if (repo.mark_done_o !== 1'b1 || repo.index_done_o !== 6'd1) begin
      n_fail++;
      $display("FAIL abort_first got=%b %0d exp=1 1",
               repo.mark_done_o, repo.index_done_o);
    end
    lock = 1'b0;
    tick();
    n_run++;
    if (repo.mark_done_o !== 1'b0 || done_ack !== 2'b00) begin
      n_fail++;
      $display("FAIL abort_drop got=stb %b ack %b exp=0 00",
               repo.mark_done_o, done_ack);
    end
    tick();
    n_run++;
    if (repo.mark_done_o !== 1'b0 || done_ack !== 2'b00) begin
      n_fail++;
      $display("FAIL abort_idle got=stb %b ack %b exp=0 00",
               repo.mark_done_o, done_ack);
    end
    lock = 1'b1;
    tick();
    n_run++;
    if (repo.mark_done_o !== 1'b1 || repo.index_done_o !== 6'd1) begin
      n_fail++;
      $display("FAIL abort_regrant got=%b %0d exp=1 1",
               repo.mark_done_o, repo.index_done_o);
    end
    repo.mark_done_valid_i = 1'b1;
    tick();
    repo.mark_done_valid_i = 1'b0;
    n_run++;
    if (done_ack !== 2'b01) begin
      n_fail++;
      $display("FAIL abort_ack got=%b exp=01", done_ack);
    end
    done_req = 2'b00;
    tick();
  endtask

  task automatic test_reset_mid();
    logic [63:0] all;
    do_reset();
    lock = 1'b1;
    done_pl[0] = '{index: 6'd3, processing: 1'b1,
                   mem_trace: 1'b1, addr: 16'h0abc};
    done_req = 2'b01;
    idx_addr[1] = 16'h4321;
    idx_req = 2'b10;
    tick();
    n_run++;
    if (repo.mark_done_o !== 1'b1 || repo.get_index_o !== 1'b1) begin
      n_fail++;
      $display("FAIL both_issue got=%b%b exp=11",
               repo.mark_done_o, repo.get_index_o);
    end
    #2;
    rst_n = 1'b0;
    #1;
    all = {repo.mark_done_o, repo.get_index_o, done_ack, idx_ack,
           idx_index, tmo_err, repo.mem_addr_o, repo.addr_o,
           repo.index_done_o, repo.processing_flag_o,
           repo.mem_trace_flag_o};
    n_run++;
    if (all !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_mid got=%0h exp=0", all);
    end
    repo.mark_done_valid_i = 1'b1;
    repo.index_valid_i     = 1'b1;
    tick();
    n_run++;
    if (done_ack !== 2'b00 || idx_ack !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_mid_noack got=%b %b exp=00 00",
               done_ack, idx_ack);
    end
    do_reset();
  endtask

  task automatic test_random();
    int         ph[2];
    int         gg[2];
    int         lst[2];
    int         wt[2];
    logic [1:0] rq[2];
    logic       vl[2];
    logic       stb[2];
    logic [1:0] ackv[2];
    logic [1:0] eack;
    logic [IDX_W-1:0] exp_idx;
    do_reset();
    lock = 1'b1;
    for (int c = 0; c < 2; c++) begin
      ph[c] = 0; gg[c] = 0; lst[c] = 1; wt[c] = 0;
      rq[c] = '0; vl[c] = 1'b0;
    end
    exp_idx = '0;
    repeat (400) begin
      tick();
      stb[0]  = repo.mark_done_o;
      stb[1]  = repo.get_index_o;
      ackv[0] = done_ack;
      ackv[1] = idx_ack;
      for (int c = 0; c < 2; c++) begin
        if (ph[c] == 0) begin
          if (rq[c] != 2'b00) begin
            gg[c] = rr_pick(lst[c], rq[c]);
            n_run++;
            if (stb[c] !== 1'b1 || ackv[c] !== 2'b00) begin
              n_fail++;
              $display("FAIL rnd_grant ch%0d got=stb %b ack %b exp=1 00",
                       c, stb[c], ackv[c]);
            end
            n_run++;
            if (c == 0 &&
                {repo.index_done_o, repo.processing_flag_o,
                 repo.mem_trace_flag_o, repo.mem_addr_o} !==
                done_pl[gg[c]]) begin
              n_fail++;
              $display("FAIL rnd_done_payload got=%h exp=%h",
                       {repo.index_done_o, repo.processing_flag_o,
                        repo.mem_trace_flag_o, repo.mem_addr_o},
                       done_pl[gg[c]]);
            end else if (c == 1 && repo.addr_o !== idx_addr[gg[c]]) begin
              n_fail++;
              $display("FAIL rnd_idx_addr got=%h exp=%h",
                       repo.addr_o, idx_addr[gg[c]]);
            end
            ph[c] = 1;
            wt[c] = $urandom_range(0, 2);
          end else begin
            n_run++;
            if (stb[c] !== 1'b0 || ackv[c] !== 2'b00) begin
              n_fail++;
              $display("FAIL rnd_idle ch%0d got=stb %b ack %b exp=0 00",
                       c, stb[c], ackv[c]);
            end
          end
        end else if (ph[c] == 1) begin
          if (vl[c]) begin
            eack = 2'b01 << gg[c];
            n_run++;
            if (ackv[c] !== eack || stb[c] !== 1'b0) begin
              n_fail++;
              $display("FAIL rnd_ack ch%0d got=ack %b stb %b exp=%b 0",
                       c, ackv[c], stb[c], eack);
            end
            if (c == 1) begin
              n_run++;
              if (idx_index !== exp_idx) begin
                n_fail++;
                $display("FAIL rnd_index got=%0d exp=%0d",
                         idx_index, exp_idx);
              end
            end
            lst[c] = gg[c];
            rq[c][gg[c]] = 1'b0;
            ph[c] = 2;
          end else begin
            n_run++;
            if (stb[c] !== 1'b1 || ackv[c] !== 2'b00) begin
              n_fail++;
              $display("FAIL rnd_hold ch%0d got=stb %b ack %b exp=1 00",
                       c, stb[c], ackv[c]);
            end
          end
        end else begin
          n_run++;
          if (stb[c] !== 1'b0 || ackv[c] !== 2'b00) begin
            n_fail++;
            $display("FAIL rnd_release ch%0d got=stb %b ack %b exp=0 00",
                     c, stb[c], ackv[c]);
          end
          ph[c] = 0;
        end
        if (ph[c] == 1) begin
          vl[c] = (wt[c] == 0);
          if (wt[c] > 0) wt[c]--;
          if ($urandom_range(0, 7) == 0) rq[c][gg[c]] = 1'b0;
        end else begin
          vl[c] = ($urandom_range(0, 3) == 0);
        end
        for (int r = 0; r < 2; r++) begin
          if (!rq[c][r] && !(ph[c] != 0 && r == gg[c]) &&
              $urandom_range(0, 2) == 0) begin
            rq[c][r] = 1'b1;
            if (c == 0) begin
              done_pl[r] = '{index: 6'($urandom),
                             processing: 1'($urandom),
                             mem_trace: 1'($urandom),
                             addr: 16'($urandom)};
            end else begin
              idx_addr[r] = 16'($urandom);
            end
          end
        end
      end
      done_req = rq[0];
      idx_req  = rq[1];
      repo.mark_done_valid_i = vl[0];
      repo.index_valid_i     = vl[1];
      repo.index_i           = IDX_W'($urandom);
      if (vl[1] && ph[1] == 1) exp_idx = repo.index_i;
    end
    n_run++;
    if (tmo_err !== 2'b00) begin
      n_fail++;
      $display("FAIL rnd_no_timeout got=%b exp=00", tmo_err);
    end
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    test_reset();
    test_single();
    test_lookup();
    test_contention();
    test_timeout();
    test_abort();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
